// File: rtl/tiny_fifo_wr_arbiter_if.sv
// Requester beat streams plus the shared FIFO write port, as seen by the arbiter.
// master = arbiter side, slave = requesters/FIFO side.
interface tiny_fifo_wr_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic [IW-1:0]  fifo_wr_id;
    logic           fifo_wr_last;
    logic           fifo_wr_full;
    logic [N-1:0]   grant;
    logic           err_overlong;

    modport master (
        input  req_valid, req_data, req_last, fifo_wr_full,
        output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id, fifo_wr_last,
               grant, err_overlong
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_wr_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id, fifo_wr_last,
               grant, err_overlong
    );
endinterface

// File: rtl/tiny_fifo_wr_arbiter.sv
// Round-robin packet-locked arbiter onto one FIFO write port; beats pass through with zero latency after a 1-cycle arbitration bubble.
// Backpressure: fifo_wr_full deasserts the owner's ready and holds the grant; non-owners always see ready low.
module tiny_fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int IW        = $clog2(N),
    parameter int MAX_BEATS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    tiny_fifo_wr_arbiter_if.master bus
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, rr_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [CW-1:0] beat_cnt, cnt_nx;
    logic          err_q, err_nx;
    logic [IW-1:0] pick;
    logic          found;
    logic          wr_en, wr_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_nx;
            owner    <= owner_nx;
            beat_cnt <= cnt_nx;
            err_q    <= err_nx;
        end
    end

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr) + k) % N]) begin
                pick  = IW'((int'(rr_ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

    // Every output is gated by GRANT so reset clears them without a clock edge.
    always_comb begin
        bus.grant        = '0;
        bus.req_ready    = '0;
        bus.fifo_wr_data = '0;
        bus.fifo_wr_id   = '0;
        wr_en            = 1'b0;
        wr_last          = 1'b0;
        if (state == GRANT) begin
            bus.grant[owner]     = 1'b1;
            bus.req_ready[owner] = ~bus.fifo_wr_full;
            wr_en                = bus.req_valid[owner] & ~bus.fifo_wr_full;
            wr_last              = bus.req_last[owner] | (beat_cnt == LAST_CNT);
            bus.fifo_wr_data     = bus.req_data[int'(owner)*W +: W];
            bus.fifo_wr_id       = owner;
        end
    end

    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_last = wr_last;
    assign bus.err_overlong = err_q;

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        cnt_nx   = beat_cnt;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nx = pick;
                    cnt_nx   = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (wr_en) begin
                    if (wr_last) begin
                        state_nx = IDLE;
                        rr_nx    = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
                        cnt_nx   = '0;
                        // Forced last without the requester's own marker: packet was cut.
                        err_nx   = ~bus.req_last[owner];
                    end else begin
                        cnt_nx = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tiny_fifo_wr_arbiter.sv
module tb_tiny_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    tiny_fifo_wr_arbiter_if #(.N(N), .W(W), .IW(IW)) bus ();

    tiny_fifo_wr_arbiter #(.N(N), .W(W), .IW(IW), .MAX_BEATS(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  grant;
        logic [3:0]  ready;
        logic        en;
        logic [7:0]  wdata;
        logic [1:0]  id;
        logic        wlast;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] l, input logic f, input logic [3:0] g,
                                input logic [3:0] r, input logic e, input logic [7:0] wd,
                                input logic [1:0] id, input logic wl, input logic er);
        vec_t x;
        x.rst = rst; x.valid = v; x.data = d; x.last = l; x.full = f;
        x.grant = g; x.ready = r; x.en = e; x.wdata = wd; x.id = id; x.wlast = wl; x.err = er;
        vecs.push_back(x);
    endfunction

    task automatic drive(input logic rst, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic f);
        reset            = rst;
        bus.req_valid    = v;
        bus.req_data     = d;
        bus.req_last     = l;
        bus.fifo_wr_full = f;
    endtask

    task automatic check(input string nm, input logic [3:0] g, input logic [3:0] r,
                         input logic e, input logic [7:0] wd, input logic [1:0] id,
                         input logic wl, input logic er);
        logic [20:0] act;
        logic [20:0] exp;
        act = {bus.grant, bus.req_ready, bus.fifo_wr_en, bus.fifo_wr_data,
               bus.fifo_wr_id, bus.fifo_wr_last, bus.err_overlong};
        exp = {g, r, e, wd, id, wl, er};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {grant,ready,en,data,id,last,err}=%b_%b_%b_%h_%0d_%b_%b, expected %b_%b_%b_%h_%0d_%b_%b",
                     nm, act[20:17], act[16:13], act[12], act[11:4], act[3:2], act[1], act[0],
                     g, r, e, wd, id, wl, er);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single requester 2: A1, A2, A3(last); then rr_ptr=3 picks req3 over req2.
        add(1, 4'b0100, 32'h00A10000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(1, 4'b0100, 32'h00A10000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'hA1, 2, 0, 0);
        add(1, 4'b0100, 32'h00A20000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'hA2, 2, 0, 0);
        add(1, 4'b0100, 32'h00A30000, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'hA3, 2, 1, 0);
        add(1, 4'b1100, 32'hB1C10000, 4'b1000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(1, 4'b1100, 32'hB1C10000, 4'b1000, 0, 4'b1000, 4'b1000, 1, 8'hB1, 3, 1, 0);
        add(1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        // Reset, then requesters 0, 1, 3 at once with 2-beat packets.
        add(0, 4'b1011, 32'h31001101, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(1, 4'b1011, 32'h31001101, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(1, 4'b1011, 32'h31001101, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'h01, 0, 0, 0);
        add(1, 4'b1011, 32'h31001102, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'h02, 0, 1, 0);
        add(1, 4'b1010, 32'h31001100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(1, 4'b1010, 32'h31001100, 4'b0000, 0, 4'b0010, 4'b0010, 1, 8'h11, 1, 0, 0);
        add(1, 4'b1010, 32'h31001200, 4'b0010, 0, 4'b0010, 4'b0010, 1, 8'h12, 1, 1, 0);
        add(1, 4'b1000, 32'h31000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(1, 4'b1000, 32'h31000000, 4'b0000, 0, 4'b1000, 4'b1000, 1, 8'h31, 3, 0, 0);
        add(1, 4'b1000, 32'h32000000, 4'b1000, 0, 4'b1000, 4'b1000, 1, 8'h32, 3, 1, 0);
        add(1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        // Req 1, 4 beats, FIFO full for 3 cycles on beat 3.
        add(1, 4'b0010, 32'h0000D100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(1, 4'b0010, 32'h0000D100, 4'b0000, 0, 4'b0010, 4'b0010, 1, 8'hD1, 1, 0, 0);
        add(1, 4'b0010, 32'h0000D200, 4'b0000, 0, 4'b0010, 4'b0010, 1, 8'hD2, 1, 0, 0);
        add(1, 4'b0010, 32'h0000D300, 4'b0000, 1, 4'b0010, 4'b0000, 0, 8'hD3, 1, 0, 0);
        add(1, 4'b0010, 32'h0000D300, 4'b0000, 1, 4'b0010, 4'b0000, 0, 8'hD3, 1, 0, 0);
        add(1, 4'b0010, 32'h0000D300, 4'b0000, 1, 4'b0010, 4'b0000, 0, 8'hD3, 1, 0, 0);
        add(1, 4'b0010, 32'h0000D300, 4'b0000, 0, 4'b0010, 4'b0010, 1, 8'hD3, 1, 0, 0);
        add(1, 4'b0010, 32'h0000D400, 4'b0010, 0, 4'b0010, 4'b0010, 1, 8'hD4, 1, 1, 0);
        add(1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);

        drive(1, 4'b0000, 32'h0, 4'b0000, 0);
        #2;
        reset = 1'b0;
        #2;
        check("reset_state", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].full);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].ready, vecs[i].en,
                  vecs[i].wdata, vecs[i].id, vecs[i].wlast, vecs[i].err);
            tick();
        end

        // Overlong: req 0 sends 20 beats, no last. rr_ptr is 2 here.
        drive(1, 4'b0001, 32'h00000001, 4'b0000, 0);
        @(negedge clk);
        check("ovl_arb", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            drive(1, 4'b0001, {24'h0, 8'(k)}, 4'b0000, 0);
            @(negedge clk);
            check($sformatf("ovl_beat%0d", k), 4'b0001, 4'b0001, 1, 8'(k), 0, (k == 16), 0);
            tick();
        end
        drive(1, 4'b0001, 32'h00000011, 4'b0000, 0);
        @(negedge clk);
        check("ovl_err_pulse", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 1);
        tick();
        for (int k = 17; k <= 20; k++) begin
            drive(1, 4'b0001, {24'h0, 8'(k)}, (k == 20) ? 4'b0001 : 4'b0000, 0);
            @(negedge clk);
            check($sformatf("ovl_tail%0d", k), 4'b0001, 4'b0001, 1, 8'(k), 0, (k == 20), 0);
            tick();
        end
        drive(1, 4'b0000, 32'h0, 4'b0000, 0);
        @(negedge clk);
        check("ovl_idle", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        tick();

        // Async reset during beat 2 of a packet from req 3 (rr_ptr=1 here).
        drive(1, 4'b1000, 32'hE1000000, 4'b0000, 0);
        @(negedge clk);
        check("ar_arb", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        tick();
        @(negedge clk);
        check("ar_beat1", 4'b1000, 4'b1000, 1, 8'hE1, 3, 0, 0);
        tick();
        drive(1, 4'b1000, 32'hE2000000, 4'b0000, 0);
        @(negedge clk);
        check("ar_beat2", 4'b1000, 4'b1000, 1, 8'hE2, 3, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_async_clear", 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
        tick();
        drive(0, 4'b0000, 32'h0, 4'b0000, 0);
        tick();

        // Release with req 0 and req 2 always requesting 1-beat packets: 0, 2, 0, 2.
        drive(1, 4'b0101, 32'h00F200F0, 4'b0101, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                check($sformatf("rr_idle%0d", c), 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0);
            end else begin
                int own;
                own = ((c / 2) % 2 == 0) ? 0 : 2;
                check($sformatf("rr_grant%0d", c), 4'(1 << own), 4'(1 << own), 1,
                      (own == 0) ? 8'hF0 : 8'hF2, 2'(own), 1, 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tiny_fifo_wr_arbiter.md
Name: tiny_fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the write port of one tiny synchronous FIFO between N requesters.
- Each requester presents a valid/ready beat stream with a last marker. The arbiter grants one requester at a time and holds the grant until that requester's last beat has been written.
- Beats are forwarded to the FIFO write port together with the owner's ID.
- Sits directly in front of the shared FIFO, in the same clock domain.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width per beat.
- IW, $clog2(N), width of the requester ID.
- MAX_BEATS, 16, maximum beats per packet; the beat counter is $clog2(MAX_BEATS+1) bits.

Ports:
- clk  in  1  single clock; everything is updated on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  N  per-requester beat valid.
- req_data  in  N*W  per-requester beat data; requester i occupies bits [i*W +: W].
- req_last  in  N  per-requester last-beat-of-packet marker.
- req_ready  out  N  per-requester ready; a beat transfers when valid and ready are both high.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  W  FIFO write data.
- fifo_wr_id  out  IW  ID of the requester whose beat is being written.
- fifo_wr_last  out  1  last flag accompanying the write.
- fifo_wr_full  in  1  FIFO full flag.
- grant  out  N  one-hot current owner; all zero when idle.
- err_overlong  out  1  one-cycle pulse when a packet reaches MAX_BEATS without last.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, err_overlong=0, grant=0.
  - All outputs are 0 immediately, including combinational ones, because they are gated by grant.
- State IDLE:
  - grant=0, req_ready=0, fifo_wr_en=0.
  - If any req_valid is high, pick the first valid index searching upward from rr_ptr, wrapping modulo N.
  - Register owner=that index, state=GRANT, beat_cnt=0.
  - The arbitration cycle is a one-cycle bubble; no beat transfers in IDLE.
- State GRANT (owner g):
  - grant = one-hot(g).
  - req_ready[g] = ~fifo_wr_full; every other req_ready is 0.
  - fifo_wr_en = req_valid[g] & ~fifo_wr_full.
  - fifo_wr_data = req_data[g]; fifo_wr_id = g.
  - fifo_wr_last = req_last[g] | (beat_cnt == MAX_BEATS-1).
  - These outputs are combinational from the registered state and current inputs, so data reaches the FIFO with zero latency.
- Beat accounting:
  - On each transfer (fifo_wr_en=1), beat_cnt increments.
  - If the transferred beat has fifo_wr_last=1: state=IDLE, rr_ptr=(g+1) mod N, beat_cnt=0.
- Overlong packets:
  - If a transfer occurs with beat_cnt==MAX_BEATS-1 and req_last[g]=0, the beat is written with fifo_wr_last forced to 1 and the grant is released as above.
  - err_overlong pulses high in the following cycle.
  - The requester's remaining beats are treated as a new packet in a later grant.
- Full FIFO: while fifo_wr_full=1, no transfer; grant is held; beat_cnt is unchanged; the requester must hold its data.
- Requester drops req_valid mid-packet: grant is held indefinitely, with no timeout. Other requesters wait.
- Fairness: after a packet completes, the owner gets lowest priority for the next arbitration. A requester waits at most N-1 packets.
- Simultaneous requests: resolved purely by rr_ptr order.
- Requests from non-owners during GRANT are ignored; their req_ready is 0.
- Throughput: a packet of L beats, with the FIFO not full and valid held high, occupies exactly L+1 cycles, including the arbitration bubble.
- Reset mid-packet: the grant is dropped immediately and the FIFO sees no further write. The packet is left truncated; recovery is the system's responsibility.

Test Plan:
- Single requester (req 2) sends a 3-beat packet with data 0xA1, 0xA2, 0xA3 and last on 0xA3, FIFO never full.
  - -> one IDLE cycle, then 3 consecutive fifo_wr_en.
  - -> fifo_wr_id=2 on each beat; fifo_wr_last only on 0xA3; back to IDLE; rr_ptr=3.
- Requesters 0, 1 and 3 all request at once after reset, each with a 2-beat packet.
  - -> grant order 0, 1, 3.
  - -> each packet is contiguous in the FIFO, with a 1-cycle bubble between packets; 9 cycles total.
- fifo_wr_full asserted for 3 cycles in the middle of a 4-beat packet from req 1.
  - -> no writes during those cycles; req_ready[1]=0; grant stays on 1.
  - -> remaining beats follow in order once full is deasserted; nothing dropped or duplicated.
- With MAX_BEATS=16, req 0 sends 20 beats with no last.
  - -> beat 16 is written with fifo_wr_last=1; err_overlong pulses the next cycle.
  - -> after re-arbitration, the remaining 4 beats form a new grant.
- Reset driven to 0 asynchronously (between clock edges) during beat 2 of a packet from req 3.
  - -> grant, fifo_wr_en and req_ready go to 0 without waiting for a clock edge.
  - -> after release, the first grant is decided from rr_ptr=0.
- Requester 0 requests continuously while req 2 also requests.
  - -> grants alternate 0, 2, 0, 2; req 0 never receives two consecutive grants while req 2 is waiting.
